// File: rtl/game_pkg.sv
// Shared game definitions: FSM states, screen geometry and the fixed-point format
// used by the ball physics.
package game_pkg;

  typedef enum logic [1:0] {IDLE, FLIGHT, SCORE, MISS} state_t;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FRAC_BITS = 4;

  // Negative coordinates pin to the screen edge rather than wrapping.
  function automatic logic [9:0] clamp_pix(input logic signed [11:0] v, input int max_v);
    if (v < 0)
      return 10'd0;
    else if (int'(v) > max_v)
      return 10'(max_v);
    else
      return v[9:0];
  endfunction

endpackage

// File: rtl/ball_trajectory_if.sv
// Scan-position, launch-control and ball-position bundle between the VGA
// pipeline and the ball physics stage.
interface ball_trajectory_if;

  logic              p_tick;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic              shoot;
  logic signed [7:0] vx0;
  logic signed [7:0] vy0;
  logic [9:0]        ball_x;
  logic [9:0]        ball_y;
  logic              in_flight;
  logic              scored;
  logic              missed;

  modport master (
    output p_tick, pixel_x, pixel_y, shoot, vx0, vy0,
    input  ball_x, ball_y, in_flight, scored, missed
  );

  modport slave (
    input  p_tick, pixel_x, pixel_y, shoot, vx0, vy0,
    output ball_x, ball_y, in_flight, scored, missed
  );

endinterface

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// single-cycle rising-edge pulse.
module btn_edge (
  input  logic CLK25MHZ,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2, prev;

  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/ball_trajectory.sv
// Per-frame ball physics: launches on a button press, integrates Q12.4 position
// with Q8.4 velocity and gravity once per vertical blank, and scores or misses.
module ball_trajectory
  import game_pkg::*;
#(
  parameter int START_X     = 10,
  parameter int START_Y     = 300,
  parameter int GRAVITY     = 1,
  parameter int FLOOR_Y     = 460,
  parameter int HOOP_X_MIN  = 560,
  parameter int HOOP_X_MAX  = 600,
  parameter int HOOP_Y      = 200,
  parameter int HOLD_FRAMES = 60
) (
  input  logic CLK25MHZ,
  input  logic reset,
  ball_trajectory_if.slave bus
);

  localparam int HOLD_W = ($clog2(HOLD_FRAMES) > 6) ? $clog2(HOLD_FRAMES) : 6;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic signed [15:0] START_PX = 16'(START_X * (1 << FRAC_BITS));
  localparam logic signed [15:0] START_PY = 16'(START_Y * (1 << FRAC_BITS));
  localparam logic signed [12:0] GRAV     = 13'(GRAVITY);

  state_t state, state_next;
  logic signed [15:0] px, py, px_next, py_next, mv_px, mv_py;
  logic signed [11:0] vx, vy, vx_next, vy_next, vy_sat;
  logic signed [12:0] vy_sum;
  logic signed [11:0] old_ny, nx, ny;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic               frame_tick, shoot_edge, launch_pend, launch_go;
  logic               hit_score, hit_miss;

  btn_edge u_shoot (
    .CLK25MHZ (CLK25MHZ),
    .reset    (reset),
    .btn      (bus.shoot),
    .pulse    (shoot_edge)
  );

  // Only the first blanking line produces a tick, so the ball never moves mid-frame.
  assign frame_tick = bus.p_tick && (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'(V_ACTIVE));

  // Candidate motion uses the pre-update velocity; vy saturates at +/-2047 LSB.
  assign mv_px  = px + {{4{vx[11]}}, vx};
  assign mv_py  = py + {{4{vy[11]}}, vy};
  assign vy_sum = $signed({vy[11], vy}) + GRAV;
  assign vy_sat = (vy_sum > 13'sd2047)  ? 12'sd2047 :
                  (vy_sum < -13'sd2047) ? -12'sd2047 : vy_sum[11:0];

  assign old_ny    = py[15:4];
  assign nx        = mv_px[15:4];
  assign ny        = mv_py[15:4];
  assign hit_score = (old_ny < HOOP_Y) && (ny >= HOOP_Y) && (nx >= HOOP_X_MIN) && (nx <= HOOP_X_MAX);
  assign hit_miss  = (ny >= FLOOR_Y) || (nx < 0) || (nx > H_ACTIVE - 1);

  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      px       <= START_PX;
      py       <= START_PY;
      vx       <= '0;
      vy       <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      px       <= px_next;
      py       <= py_next;
      vx       <= vx_next;
      vy       <= vy_next;
      hold_cnt <= hold_next;
    end
  end

  // A launch on the same tick as a fresh press wins, so the press is not re-queued.
  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset)
      launch_pend <= 1'b0;
    else if (launch_go)
      launch_pend <= 1'b0;
    else if (shoot_edge && state == IDLE)
      launch_pend <= 1'b1;
  end

  always_comb begin
    state_next = state;
    px_next    = px;
    py_next    = py;
    vx_next    = vx;
    vy_next    = vy;
    hold_next  = hold_cnt;
    launch_go  = 1'b0;
    case (state)
      IDLE: begin
        px_next = START_PX;
        py_next = START_PY;
        if (frame_tick && launch_pend) begin
          launch_go  = 1'b1;
          vx_next    = {{4{bus.vx0[7]}}, bus.vx0};
          vy_next    = {{4{bus.vy0[7]}}, bus.vy0};
          state_next = FLIGHT;
        end
      end
      FLIGHT: begin
        if (frame_tick) begin
          px_next = mv_px;
          py_next = mv_py;
          vy_next = vy_sat;
          if (hit_score) begin
            state_next = SCORE;
            hold_next  = HOLD_LOAD;
          end else if (hit_miss) begin
            state_next = MISS;
            hold_next  = HOLD_LOAD;
          end
        end
      end
      SCORE, MISS: begin
        if (frame_tick) begin
          if (hold_cnt == '0) begin
            state_next = IDLE;
            px_next    = START_PX;
            py_next    = START_PY;
            vx_next    = '0;
            vy_next    = '0;
          end else begin
            hold_next = hold_cnt - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_flight = (state == FLIGHT);
    bus.scored    = (state == SCORE);
    bus.missed    = (state == MISS);
    bus.ball_x    = clamp_pix(px[15:4], H_ACTIVE - 1);
    bus.ball_y    = clamp_pix(py[15:4], V_ACTIVE - 1);
  end

endmodule

// File: tb/tb_ball_trajectory.sv
// Directed bench: three ball_trajectory instances (default, scoring and missing
// configurations) driven by a shortened synthetic frame of four pixel cycles.
module tb_ball_trajectory;

  logic       CLK25MHZ;
  logic [2:0] rst;
  logic [2:0] shoot;
  logic       p_tick;
  logic [9:0] pixel_x, pixel_y;
  int         tests_run;
  int         tests_failed;

  ball_trajectory_if if_a ();
  ball_trajectory_if if_s ();
  ball_trajectory_if if_m ();

  assign if_a.p_tick = p_tick;  assign if_a.pixel_x = pixel_x;  assign if_a.pixel_y = pixel_y;
  assign if_s.p_tick = p_tick;  assign if_s.pixel_x = pixel_x;  assign if_s.pixel_y = pixel_y;
  assign if_m.p_tick = p_tick;  assign if_m.pixel_x = pixel_x;  assign if_m.pixel_y = pixel_y;
  assign if_a.shoot = shoot[0];  assign if_s.shoot = shoot[1];  assign if_m.shoot = shoot[2];
  assign if_a.vx0 = 8'sh20;  assign if_a.vy0 = 8'shC0;
  assign if_s.vx0 = 8'sh00;  assign if_s.vy0 = 8'sh10;
  assign if_m.vx0 = 8'sh00;  assign if_m.vy0 = 8'sh7F;

  ball_trajectory dut_a (.CLK25MHZ(CLK25MHZ), .reset(rst[0]), .bus(if_a));

  ball_trajectory #(.GRAVITY(0), .HOOP_X_MIN(5), .HOOP_X_MAX(20), .HOOP_Y(310))
    dut_s (.CLK25MHZ(CLK25MHZ), .reset(rst[1]), .bus(if_s));

  ball_trajectory #(.GRAVITY(0))
    dut_m (.CLK25MHZ(CLK25MHZ), .reset(rst[2]), .bus(if_m));

  logic [9:0] bx [3];
  logic [9:0] by [3];
  logic       fl [3];
  logic       sc [3];
  logic       ms [3];

  assign bx[0] = if_a.ball_x;  assign by[0] = if_a.ball_y;
  assign fl[0] = if_a.in_flight;  assign sc[0] = if_a.scored;  assign ms[0] = if_a.missed;
  assign bx[1] = if_s.ball_x;  assign by[1] = if_s.ball_y;
  assign fl[1] = if_s.in_flight;  assign sc[1] = if_s.scored;  assign ms[1] = if_s.missed;
  assign bx[2] = if_m.ball_x;  assign by[2] = if_m.ball_y;
  assign fl[2] = if_m.in_flight;  assign sc[2] = if_m.scored;  assign ms[2] = if_m.missed;

  initial CLK25MHZ = 1'b0;
  always #20 CLK25MHZ = ~CLK25MHZ;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_state(input int d, input string tag, input int x, input int y,
                             input int f, input int s, input int m);
    checkOutput({tag, " ball_x"},    32'(bx[d]), x);
    checkOutput({tag, " ball_y"},    32'(by[d]), y);
    checkOutput({tag, " in_flight"}, 32'(fl[d]), f);
    checkOutput({tag, " scored"},    32'(sc[d]), s);
    checkOutput({tag, " missed"},    32'(ms[d]), m);
  endtask

  task automatic cycle();
    @(posedge CLK25MHZ);
    #1;
  endtask

  task automatic tick_cycle();
    p_tick  = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'd480;
    cycle();
    pixel_x = 10'd5;
    pixel_y = 10'd100;
  endtask

  // One synthetic frame: three active-area pixels, then the blanking tick.
  task automatic applyStimulus(input int frames);
    for (int i = 0; i < frames; i++) begin
      p_tick  = 1'b1;
      pixel_x = 10'd5;
      pixel_y = 10'd100;
      repeat (3) cycle();
      tick_cycle();
    end
  endtask

  task automatic pulse_shoot(input int d);
    shoot[d] = 1'b1;
    repeat (4) cycle();
    shoot[d] = 1'b0;
    repeat (4) cycle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 3'b111;
    shoot        = 3'b000;
    p_tick       = 1'b0;
    pixel_x      = 10'd5;
    pixel_y      = 10'd100;
    repeat (2) cycle();

    check_state(0, "reset_a", 10, 300, 0, 0, 0);
    check_state(1, "reset_s", 10, 300, 0, 0, 0);
    check_state(2, "reset_m", 10, 300, 0, 0, 0);
    rst = 3'b000;
    applyStimulus(3);
    check_state(0, "idle_3f", 10, 300, 0, 0, 0);

    // A blanking position without p_tick must not consume the pending launch.
    pulse_shoot(0);
    p_tick  = 1'b0;
    pixel_x = 10'd0;
    pixel_y = 10'd480;
    cycle();
    check_state(0, "no_ptick", 10, 300, 0, 0, 0);
    applyStimulus(1);
    check_state(0, "launch_a", 10, 300, 1, 0, 0);
    applyStimulus(1);
    check_state(0, "flight_a1", 12, 296, 1, 0, 0);
    applyStimulus(1);
    check_state(0, "flight_a2", 14, 292, 1, 0, 0);

    // Asynchronous reset in flight returns to start within the same cycle.
    rst[0] = 1'b1;
    #1;
    check_state(0, "reset_mid", 10, 300, 0, 0, 0);
    cycle();
    rst[0] = 1'b0;

    pulse_shoot(1);
    applyStimulus(1);
    check_state(1, "launch_s", 10, 300, 1, 0, 0);
    applyStimulus(4);
    check_state(1, "flight_s4", 10, 304, 1, 0, 0);
    pulse_shoot(1);
    applyStimulus(5);
    check_state(1, "flight_s9", 10, 309, 1, 0, 0);
    applyStimulus(1);
    check_state(1, "score_s10", 10, 310, 0, 1, 0);
    pulse_shoot(1);
    applyStimulus(59);
    check_state(1, "score_hold", 10, 310, 0, 1, 0);
    applyStimulus(1);
    check_state(1, "score_back", 10, 300, 0, 0, 0);
    applyStimulus(3);
    check_state(1, "no_relaunch", 10, 300, 0, 0, 0);
    pulse_shoot(1);
    applyStimulus(1);
    check_state(1, "relaunch_s", 10, 300, 1, 0, 0);

    // Edge pulse lands on the frame_tick cycle: queued, launches on the next tick.
    shoot[2] = 1'b1;
    cycle();
    cycle();
    tick_cycle();
    shoot[2] = 1'b0;
    check_state(2, "simul_tick", 10, 300, 0, 0, 0);
    applyStimulus(1);
    check_state(2, "launch_m", 10, 300, 1, 0, 0);
    applyStimulus(20);
    check_state(2, "flight_m20", 10, 458, 1, 0, 0);
    applyStimulus(1);
    check_state(2, "miss_m21", 10, 466, 0, 0, 1);
    applyStimulus(59);
    check_state(2, "miss_hold", 10, 466, 0, 0, 1);
    applyStimulus(1);
    check_state(2, "miss_back", 10, 300, 0, 0, 0);

    pulse_shoot(2);
    rst[2] = 1'b1;
    cycle();
    rst[2] = 1'b0;
    applyStimulus(1);
    check_state(2, "pend_cleared", 10, 300, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ball_trajectory.md
# ball_trajectory

- Per-frame ball physics stage that feeds `ball_x`/`ball_y` to the pixel generator in the VGA pipeline, replacing the constant coordinates.
- Detects start of vertical blanking from the sync counters, launches a shot on a button press, and integrates position with fixed-point velocity and gravity.
- Classifies each shot as score or miss, holds the result, then returns the ball to the start position.

## Interface
Parameters:
- `START_X`, 10: idle ball x (pixels)
- `START_Y`, 300: idle ball y (pixels)
- `GRAVITY`, 1: added to vy each frame, in 1/16 px/frame² (Q8.4 LSBs)
- `FLOOR_Y`, 460: miss when integer y ≥ this
- `HOOP_X_MIN`, 560 / `HOOP_X_MAX`, 600: inclusive hoop x window
- `HOOP_Y`, 200: hoop rim line
- `HOLD_FRAMES`, 60: frames to hold SCORE/MISS

Ports:
- `CLK25MHZ` in 1: pixel clock
- `reset` in 1: asynchronous, active-high
- `p_tick` in 1: pixel enable from vga_sync
- `pixel_x` in 10: current scan x
- `pixel_y` in 10: current scan y
- `shoot` in 1: raw button, asynchronous to clock
- `vx0` in 8: signed Q4.4 launch x velocity (px/frame)
- `vy0` in 8: signed Q4.4 launch y velocity (negative = up)
- `ball_x` out 10: ball x, clamped 0..639
- `ball_y` out 10: ball y, clamped 0..479
- `in_flight` out 1: state == FLIGHT
- `scored` out 1: state == SCORE
- `missed` out 1: state == MISS

## Operation
- **frame_tick**
  - Asserted when `p_tick && pixel_x==0 && pixel_y==480`, the first blanking line.
  - All physics and state updates happen only on frame_tick, so outputs stay constant across every active frame.
- **shoot path**
  - 2-FF synchronizer, then rising-edge detect.
  - An edge in IDLE sets `launch_pend`.
  - Edges in any other state are discarded.
- **Position registers**
  - `px`, `py`: 16-bit signed Q12.4.
- **Velocity registers**
  - `vx`, `vy`: 12-bit signed Q8.4.
  - Saturate at ±2047 LSB.
- **State machine**
  - IDLE:
    - `px=START_X<<4`, `py=START_Y<<4`.
    - On frame_tick with `launch_pend`: load `vx`/`vy` from sign-extended `vx0`/`vy0`, clear `launch_pend`, go to FLIGHT.
    - No motion occurs on the launch tick.
  - FLIGHT, on each frame_tick:
    - `px+=vx`, `py+=vy`, `vy+=GRAVITY`. Position uses the pre-update velocity.
    - Then evaluate the new integer position `nx=px[15:4]`, `ny=py[15:4]`, in priority order:
      - Score: old `ny < HOOP_Y ≤ new ny` and `HOOP_X_MIN ≤ nx ≤ HOOP_X_MAX` → SCORE.
      - Miss: `ny ≥ FLOOR_Y`, or `nx < 0`, or `nx > 639` → MISS.
      - Otherwise remain in FLIGHT.
  - SCORE / MISS:
    - Position frozen.
    - 6-bit-min hold counter, loaded with HOLD_FRAMES-1 on entry and decremented per frame_tick.
    - At 0 on a frame_tick: go to IDLE and reload the start position.
- **Output clamping**
  - `ball_x`/`ball_y` = integer part clamped to 0..639 / 0..479. Negative values map to 0.
- **Reset mid-operation**
  - Forces IDLE from any state.
  - Clears `launch_pend`, synchronizer, and counters.

## Timing
- **Reset values**
  - `ball_x=START_X`, `ball_y=START_Y`.
  - `in_flight=0`, `scored=0`, `missed=0`.
  - `vx=vy=0`.
- **Update latency**
  - All outputs are registered.
  - They change on the clock edge after the frame_tick cycle and nowhere else.
- **Launch latency**
  - From a `shoot` edge to `in_flight`=1: 2–3 cycles of sync/edge detect, then the next frame_tick.
  - First motion occurs one frame later.
- **Simultaneous events**
  - A shoot edge on the same cycle as frame_tick in IDLE sets `launch_pend`. It launches at the following frame_tick.
  - Score and miss on the same tick resolve to SCORE.
- **Flag exclusivity**
  - At most one of `in_flight`/`scored`/`missed` is high at any time.
- **Pixel enable**
  - Without `p_tick` no frame_tick occurs and the state holds.

## Structure
- **Shared package `game_pkg`**
  - State enum {IDLE, FLIGHT, SCORE, MISS}.
  - Screen constants H_ACTIVE=640, V_ACTIVE=480.
  - Fixed-point FRAC_BITS=4.
- **Sub-module `btn_edge`**
  - 2-FF synchronizer plus rising-edge pulse.
  - Reused for future buttons.
- **Top-level change**
  - Instantiated in the VGA top.
  - Outputs drive pixel_Gen `ball_x`/`ball_y` in place of the constants.

## Test plan
- Reset held then released, no shoot → `ball_x=10`, `ball_y=300`, all flags 0 for 3 frames.
- `vx0=8'h20`, `vy0=8'hC0`, GRAVITY=1, pulse shoot:
  - Next tick: `in_flight=1`, still at (10,300).
  - +1 frame: (12,296).
  - +2 frames: (14,292).
- GRAVITY=0, HOOP_X 5..20, HOOP_Y=310, `vx0=0`, `vy0=8'h10` → y=301..310. `scored=1` after frame 10, held 60 frames, then back to (10,300) IDLE.
- GRAVITY=0, `vx0=0`, `vy0=8'h7F` → `missed=1` at frame 21 (y=466). Returns to IDLE after HOLD_FRAMES.
- Shoot pulses during FLIGHT and SCORE → ignored. No relaunch after returning to IDLE unless a new press occurs.
- Assert reset mid-FLIGHT → same cycle: `ball_x/ball_y`=(10,300), `in_flight=0`. A pending launch is discarded.
